mmio_bank_ctrl: RTL and testbench

//   Downstream consumer of the address decoder. Takes the decoder's one-hot register select and RAM select for each bus request.
//   Low addresses (RAM_S=0) read or write one of NUM_REGS internal data registers; high addresses (RAM_S=1) go to external RAM

---
 rtl/mmio_bank_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mmio_bank_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bank_ctrl.sv
// mmio_bank_ctrl: register bank plus external-RAM bridge behind the address decoder.
// Low addresses hit NUM_REGS internal registers; high addresses go to RAM over a
// REQ/ACK handshake with a timeout. One ACK pulse per request, ERR flags failures.
module mmio_bank_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_REGS = 12,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   add,
  input  logic [NUM_REGS-1:0] sel,
  input  logic                ram_s,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic                ram_ack
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REG      = 2'd1,
    S_RAM_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic                  we_q;
  logic [NUM_REGS-1:0]   sel_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];

  logic [DATA_W-1:0]     rdata_d;
  logic                  ack_d;
  logic                  err_d;
  logic                  ram_req_d;
  logic                  accept_c;
  logic                  reg_wr_c;
  logic                  sel_ok_c;
  logic [DATA_W-1:0]     reg_rd_c;

  // Exactly one select bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_ok_c = (sel_q != '0) && ((sel_q & (sel_q - NUM_REGS'(1))) == '0);

  // Selected register read data (OR-mux, valid only when the select is one-hot).
  always_comb begin
    reg_rd_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_q[i]) reg_rd_c = reg_rd_c | regs_q[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata;
    ack_d     = ack;
    err_d     = err;
    ram_req_d = ram_req;
    accept_c  = 1'b0;
    reg_wr_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept_c = 1'b1;
          if (ram_s) begin
            ram_req_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_RAM_WAIT;
          end else begin
            state_d   = S_REG;
          end
        end
      end
      S_REG: begin
        ack_d   = 1'b1;
        state_d = S_DONE;
        if (sel_ok_c) begin
          if (we_q) reg_wr_c = 1'b1;
          else      rdata_d  = reg_rd_c;
        end else begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      S_RAM_WAIT: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          ack_d     = 1'b1;
          if (!ram_we) rdata_d = ram_rdata;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          ram_req_d = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d     = cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, request capture and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rdata   <= rdata_d;
      ack     <= ack_d;
      err     <= err_d;
      ram_req <= ram_req_d;
      if (accept_c) begin
        we_q    <= we;
        sel_q   <= sel;
        wdata_q <= wdata;
        if (ram_s) begin
          ram_we    <= we;
          ram_addr  <= add;
          ram_wdata <= wdata;
        end
      end
    end
  end

  // Register bank write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_wr_c) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel_q[i]) regs_q[i] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bank_ctrl.sv
// Directed bench for mmio_bank_ctrl: register bank, bad selects, RAM handshake,
// timeout, reset during a RAM wait, back-to-back requests and stray RAM_ACK.
module tb_mmio_bank_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [11:0] add;
  logic [11:0] sel;
  logic        ram_s;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        ram_req;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ack;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_bank_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .add       (add),
    .sel       (sel),
    .ram_s     (ram_s),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register access: E0 accept, E1 ACK, E2 back to IDLE.
  task automatic reg_access(input string tag, input logic w, input logic [11:0] s,
                            input logic [15:0] d, input logic e_err,
                            input logic chk_rd, input logic [15:0] e_rd);
    req = 1'b1; we = w; ram_s = 1'b0; sel = s; wdata = d; add = 12'h010;
    tick();
    req = 1'b0;
    chk({tag, ".ack_e0"}, 32'(ack), 32'd0);
    tick();
    chk({tag, ".ack"}, 32'(ack), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    if (chk_rd) chk({tag, ".rdata"}, 32'(rdata), 32'(e_rd));
    tick();
    chk({tag, ".ack_done"}, 32'(ack), 32'd0);
    chk({tag, ".err_done"}, 32'(err), 32'd0);
  endtask

  // RAM access; ack_at = wait edge on which RAM_ACK is presented (0 = never).
  task automatic ram_access(input string tag, input logic w, input logic [11:0] a,
                            input logic [15:0] d, input int ack_at,
                            input logic [15:0] rd, input logic e_err,
                            input logic [15:0] e_rd, input int e_high);
    int high;
    int wcnt;
    logic addr_ok;
    req = 1'b1; we = w; ram_s = 1'b1; sel = 12'h000; add = a; wdata = d;
    tick();
    req = 1'b0; add = 12'h000; wdata = 16'h0000; we = ~w;
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(w));
    if (w) chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(d));
    high = 0; wcnt = 0; addr_ok = 1'b1;
    while (ram_req && wcnt < 40) begin
      high++;
      wcnt++;
      if (ram_addr !== a || ack !== 1'b0) addr_ok = 1'b0;
      ram_ack   = (wcnt == ack_at);
      ram_rdata = (wcnt == ack_at) ? rd : 16'hDEAD;
      tick();
    end
    ram_ack = 1'b0;
    chk({tag, ".req_cycles"}, 32'(high), 32'(e_high));
    chk({tag, ".addr_stable"}, 32'(addr_ok), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    chk({tag, ".rdata"}, 32'(rdata), 32'(e_rd));
    tick();
    chk({tag, ".ack_done"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int acks;
    int errs;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; add = '0; sel = '0; ram_s = 1'b0;
    wdata = '0; ram_rdata = '0; ram_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", 32'(rdata), 32'd0);
    chk("rst.ram_req", 32'(ram_req), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: write then read register 2
    reg_access("wr_r2", 1'b1, 12'h004, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    reg_access("rd_r2", 1'b0, 12'h004, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    reg_access("wr_r11", 1'b1, 12'h800, 16'h7E57, 1'b0, 1'b0, 16'h0);
    reg_access("rd_r11", 1'b0, 12'h800, 16'h0000, 1'b0, 1'b1, 16'h7E57);

    // 2: bad selects
    reg_access("rd_sel0", 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 16'h0000);
    reg_access("rd_r2b", 1'b0, 12'h004, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    reg_access("rd_sel3", 1'b0, 12'h003, 16'h0000, 1'b1, 1'b1, 16'h0000);
    reg_access("wr_sel3", 1'b1, 12'h003, 16'h1111, 1'b1, 1'b1, 16'h0000);
    reg_access("rd_r0", 1'b0, 12'h001, 16'h0000, 1'b0, 1'b1, 16'h0000);
    reg_access("rd_r1", 1'b0, 12'h002, 16'h0000, 1'b0, 1'b1, 16'h0000);
    reg_access("rd_r2c", 1'b0, 12'h004, 16'h0000, 1'b0, 1'b1, 16'hBEEF);

    // 3: RAM read, RAM_ACK on the 4th wait edge; SEL ignored for RAM accesses
    ram_access("ram_rd", 1'b0, 12'h0C0, 16'h0, 4, 16'h1234, 1'b0, 16'h1234, 4);
    ram_access("ram_rd1", 1'b0, 12'hFFF, 16'h0, 1, 16'hABCD, 1'b0, 16'hABCD, 1);

    // 4: timeout on write, then RAM_ACK on the final (15th) edge wins
    ram_access("ram_to", 1'b1, 12'h0C4, 16'h5555, 0, 16'h0, 1'b1, 16'hABCD, 15);
    ram_access("ram_ack15", 1'b1, 12'h0C8, 16'hAAAA, 15, 16'h0, 1'b0, 16'hABCD, 15);
    ram_access("ram_rd_to", 1'b0, 12'h0CC, 16'h0, 0, 16'h0, 1'b1, 16'hABCD, 15);

    // 5: reset in the middle of a RAM wait
    req = 1'b1; we = 1'b0; ram_s = 1'b1; add = 12'h0C0;
    tick();
    req = 1'b0;
    chk("rstw.ram_req_before", 32'(ram_req), 32'd1);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw.ram_req_async", 32'(ram_req), 32'd0);
    chk("rstw.ack_async", 32'(ack), 32'd0);
    chk("rstw.rdata_async", 32'(rdata), 32'd0);
    ram_ack = 1'b1; ram_rdata = 16'h9999;
    tick();
    ram_ack = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("rstw.no_stray_ack", 32'(acks), 32'd0);
    chk("rstw.ram_req_after", 32'(ram_req), 32'd0);
    reg_access("rstw.rd_r2", 1'b0, 12'h004, 16'h0, 1'b0, 1'b1, 16'h0000);
    reg_access("rstw.rd_r11", 1'b0, 12'h800, 16'h0, 1'b0, 1'b1, 16'h0000);

    // 6: back-to-back register reads with REQ held high
    reg_access("b2b.wr_r0", 1'b1, 12'h001, 16'h5A5A, 1'b0, 1'b0, 16'h0);
    req = 1'b1; we = 1'b0; ram_s = 1'b0; sel = 12'h001;
    acks = 0; errs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack) acks++;
      if (err) errs++;
    end
    req = 1'b0;
    chk("b2b.ack_count", 32'(acks), 32'd4);
    chk("b2b.err_count", 32'(errs), 32'd0);
    chk("b2b.rdata", 32'(rdata), 32'h5A5A);
    tick(); tick();

    // Stray RAM_ACK while idle
    ram_ack = 1'b1; ram_rdata = 16'hFACE;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack || ram_req) acks++;
    end
    ram_ack = 1'b0;
    chk("stray.no_effect", 32'(acks), 32'd0);
    chk("stray.rdata", 32'(rdata), 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
